// File: rtl/eq_coeff_bank_pkg.sv
// Shared constants, FSM state type and helper functions for the equalizer coefficient bank.
package eq_pkg;

  localparam int NR_EQ_BAND_COEFF = 5;

  // Coefficient order within one biquad band; A1/A2 are stored pre-negated.
  localparam int B0 = 0;
  localparam int B1 = 1;
  localparam int B2 = 2;
  localparam int A1 = 3;
  localparam int A2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_PEND
  } load_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // 1.0 in Q4.(width-4).
  function automatic longint unsigned EQ_COEFF_UNITY(input int width);
    return longint'(1) << (width - 4);
  endfunction

endpackage

// File: rtl/eq_coeff_bank_if.sv
// Host coefficient write stream (AXI-stream style, no backpressure on the host side beyond tready).
interface eq_coeff_bank_if #(
  parameter int EQ_COEFF_WIDTH = 32
) ();

  logic [EQ_COEFF_WIDTH-1:0] s_tdata;
  logic                      s_tvalid;
  logic                      s_tready;
  logic                      s_tlast;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input  s_tready);
  modport slave  (input  s_tdata, input  s_tvalid, input  s_tlast, output s_tready);

endinterface

// File: rtl/eq_coeff_ram.sv
// One coefficient bank: synchronous write, registered read(s), preloaded with a unity passthrough set.
// With EQ_COEFF_BANK_READBACK_EN defined a second registered read port is added.
module eq_coeff_ram
  import eq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 160,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
`ifdef EQ_COEFF_BANK_READBACK_EN
  ,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [WIDTH-1:0]      rb_data
`endif
);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t unity_image();
    mem_t img;
    for (int i = 0; i < DEPTH; i++)
      img[i] = ((i % NR_EQ_BAND_COEFF) == B0) ? WIDTH'(EQ_COEFF_UNITY(WIDTH)) : '0;
    return img;
  endfunction

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH + 1)'(DEPTH);
  endfunction

  // NOTE: the array is preloaded and deliberately never reset, so reset keeps the
  // active set intact and the storage can map onto block RAM.
  mem_t mem = unity_image();

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // NOTE: sequential state is always assigned with <= so every register samples
  // pre-edge values regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= in_range(raddr) ? mem[raddr] : '0;
  end

`ifdef EQ_COEFF_BANK_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst) rb_data <= '0;
    else     rb_data <= in_range(rb_addr) ? mem[rb_addr] : '0;
  end
`endif

endmodule

// File: rtl/eq_coeff_bank.sv
// Double-buffered biquad coefficient store: host loads the shadow bank, swap happens while the equalizer idles.
// Optional host readback port enabled by EQ_COEFF_BANK_READBACK_EN.
module eq_coeff_bank
  import eq_pkg::*;
#(
  parameter  int NR_CHANNELS         = 4,
  parameter  int NR_EQ_BANDS         = 8,
  parameter  int EQ_COEFF_WIDTH      = 32,
  localparam int NR_EQ_COEFF         = NR_CHANNELS * NR_EQ_BANDS * NR_EQ_BAND_COEFF,
  localparam int EQ_COEFF_ADDR_WIDTH = (NR_EQ_COEFF > 1) ? clog2(NR_EQ_COEFF) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EQ_COEFF_ADDR_WIDTH-1:0] eq_coeff_addr,
  output logic [EQ_COEFF_WIDTH-1:0]      eq_coeff,
  eq_coeff_bank_if.slave                 s,
  input  logic                           swap_en,
  output logic                           active_bank,
  output logic                           load_done,
  output logic                           load_error
`ifdef EQ_COEFF_BANK_READBACK_EN
  ,
  input  logic [EQ_COEFF_ADDR_WIDTH-1:0] rb_addr,
  input  logic                           rb_bank,
  output logic [EQ_COEFF_WIDTH-1:0]      rb_data
`endif
);

  localparam logic [EQ_COEFF_ADDR_WIDTH-1:0] LAST_ADDR = EQ_COEFF_ADDR_WIDTH'(NR_EQ_COEFF - 1);

  load_state_e                    state_q, state_d;
  logic [EQ_COEFF_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                           bank_d, done_d, error_d, wr_en, accept;
  logic                           rd_bank_q;
  logic [EQ_COEFF_WIDTH-1:0]      bank_rdata [2];

  assign s.s_tready = ~rst && (state_q != ST_PEND);
  assign accept     = s.s_tvalid && s.s_tready;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    bank_d  = active_bank;
    done_d  = 1'b0;
    error_d = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      // IDLE always has ptr 0, so it shares the LOAD word handling.
      ST_IDLE, ST_LOAD: begin
        if (accept) begin
          wr_en = 1'b1;
          if (ptr_q == LAST_ADDR) begin
            ptr_d = '0;
            if (s.s_tlast) begin
              state_d = ST_PEND;
            end else begin
              error_d = 1'b1;
              state_d = ST_DRAIN;
            end
          end else if (s.s_tlast) begin
            error_d = 1'b1;
            ptr_d   = '0;
            state_d = ST_IDLE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = ST_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s.s_tlast) begin
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_PEND: begin
        if (swap_en) begin
          bank_d  = ~active_bank;
          done_d  = 1'b1;
          ptr_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      active_bank <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      active_bank <= bank_d;
      load_done   <= done_d;
      load_error  <= error_d;
      // Bank select travels with the sampled address, so a swap-cycle read sees the old bank.
      rd_bank_q   <= active_bank;
    end
  end

`ifdef EQ_COEFF_BANK_READBACK_EN
  logic                      rb_bank_q;
  logic [EQ_COEFF_WIDTH-1:0] rb_rdata [2];

  always_ff @(posedge clk) begin
    if (rst) rb_bank_q <= 1'b0;
    else     rb_bank_q <= rb_bank;
  end

  assign rb_data = rb_bank_q ? rb_rdata[1] : rb_rdata[0];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_bank
    eq_coeff_ram #(
      .WIDTH      (EQ_COEFF_WIDTH),
      .DEPTH      (NR_EQ_COEFF),
      .ADDR_WIDTH (EQ_COEFF_ADDR_WIDTH)
    ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .we      (wr_en && (active_bank != 1'(g))),
      .waddr   (ptr_q),
      .wdata   (s.s_tdata),
      .raddr   (eq_coeff_addr),
      .rdata   (bank_rdata[g])
`ifdef EQ_COEFF_BANK_READBACK_EN
      ,
      .rb_addr (rb_addr),
      .rb_data (rb_rdata[g])
`endif
    );
  end

  assign eq_coeff = rd_bank_q ? bank_rdata[1] : bank_rdata[0];

endmodule

// File: tb/tb_eq_coeff_bank.sv
// Directed bench for eq_coeff_bank: read sweep table plus load/swap/error/reset sequences.
module tb_eq_coeff_bank;

  localparam int W     = 32;
  localparam int N     = 160;
  localparam int AW    = 8;
  localparam logic [W-1:0] UNITY = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] eq_coeff_addr;
  logic [W-1:0]  eq_coeff;
  logic          swap_en;
  logic          active_bank;
  logic          load_done;
  logic          load_error;

  always #5 clk = ~clk;

  eq_coeff_bank_if #(.EQ_COEFF_WIDTH(W)) s_bus ();

`ifdef EQ_COEFF_BANK_READBACK_EN
  logic [AW-1:0] rb_addr;
  logic          rb_bank;
  logic [W-1:0]  rb_data;
`endif

  eq_coeff_bank #(
    .NR_CHANNELS    (4),
    .NR_EQ_BANDS    (8),
    .EQ_COEFF_WIDTH (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .eq_coeff_addr (eq_coeff_addr),
    .eq_coeff      (eq_coeff),
    .s             (s_bus.slave),
    .swap_en       (swap_en),
    .active_bank   (active_bank),
    .load_done     (load_done),
    .load_error    (load_error)
`ifdef EQ_COEFF_BANK_READBACK_EN
    ,
    .rb_addr       (rb_addr),
    .rb_bank       (rb_bank),
    .rb_data       (rb_data)
`endif
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  exp;
  } rd_vec_t;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  bit both_seen = 1'b0;

  always @(negedge clk) begin
    if (load_done)  done_cnt++;
    if (load_error) err_cnt++;
    if (load_done && load_error) both_seen = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_check(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
    eq_coeff_addr = a;
    @(negedge clk);
    check(name, eq_coeff, exp);
  endtask

  // Sends words first..first+count-1 with data base+index; tlast on index last_pos.
  task automatic send_words(input int first, input int count, input int last_pos, input logic [W-1:0] base);
    for (int i = first; i < first + count; i++) begin
      int wt;
      s_bus.s_tdata  = base + W'(i);
      s_bus.s_tlast  = (i == last_pos);
      s_bus.s_tvalid = 1'b1;
      wt = 0;
      while (!s_bus.s_tready && wt < 200) begin
        @(negedge clk);
        wt++;
      end
      if (!s_bus.s_tready) begin
        check("tready_timeout", W'(s_bus.s_tready), 32'd1);
        break;
      end
      @(negedge clk);
    end
    s_bus.s_tvalid = 1'b0;
    s_bus.s_tlast  = 1'b0;
  endtask

  task automatic wait_done();
    int wt;
    wt = 0;
    while (!load_done && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    check("load_done_seen", W'(load_done), 32'd1);
  endtask

  initial begin
    rd_vec_t sweep[$];
    int      d0, e0;

    for (int a = 0; a < N; a++) sweep.push_back('{AW'(a), (a % 5 == 0) ? UNITY : 32'd0});
    sweep.push_back('{8'd160, 32'd0});
    sweep.push_back('{8'd200, 32'd0});
    sweep.push_back('{8'd255, 32'd0});

    rst            = 1'b1;
    eq_coeff_addr  = '0;
    swap_en        = 1'b0;
    s_bus.s_tdata  = '0;
    s_bus.s_tvalid = 1'b0;
    s_bus.s_tlast  = 1'b0;
`ifdef EQ_COEFF_BANK_READBACK_EN
    rb_addr = '0;
    rb_bank = 1'b0;
`endif

    // Reset state.
    idle(2);
    check("rst_tready",      W'(s_bus.s_tready), 32'd0);
    check("rst_eq_coeff",    eq_coeff,           32'd0);
    check("rst_active_bank", W'(active_bank),    32'd0);
    check("rst_load_done",   W'(load_done),      32'd0);
    check("rst_load_error",  W'(load_error),     32'd0);
`ifdef EQ_COEFF_BANK_READBACK_EN
    check("rst_rb_data",     rb_data,            32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    check("idle_tready", W'(s_bus.s_tready), 32'd1);

    // Unity passthrough sweep, including out-of-range addresses.
    foreach (sweep[i]) read_check("init_sweep", sweep[i].addr, sweep[i].exp);
    check("init_active_bank", W'(active_bank), 32'd0);

    // Full load, held pending for 50 cycles, then swap.
    d0 = done_cnt;
    send_words(0, N, N - 1, 32'd0);
    check("pend_tready", W'(s_bus.s_tready), 32'd0);
    for (int c = 0; c < 50; c++) begin
      read_check("pend_old_data", 8'd35, UNITY);
      check("pend_bank", W'(active_bank), 32'd0);
    end
    swap_en       = 1'b1;
    eq_coeff_addr = 8'd35;
    @(negedge clk);
    check("swap_cycle_old_data", eq_coeff,        UNITY);
    check("swap_bank",           W'(active_bank), 32'd1);
    check("swap_done_pulse",     W'(load_done),   32'd1);
    swap_en = 1'b0;
    @(negedge clk);
    check("swap_done_end",       W'(load_done),   32'd0);
    check("swap_new_data",       eq_coeff,        32'd35);
    read_check("new_addr37", 8'd37, 32'd37);
    idle(2);
    check("swap_done_count", W'(done_cnt - d0), 32'd1);

    // Short set (tlast on word 10), then a valid set swapped immediately.
    e0 = err_cnt;
    d0 = done_cnt;
    send_words(0, 11, 10, 32'hdead_0000);
    idle(2);
    check("short_err_count", W'(err_cnt - e0), 32'd1);
    check("short_bank",      W'(active_bank),   32'd1);
    read_check("short_keep37", 8'd37, 32'd37);
    read_check("short_keep5",  8'd5,  32'd5);
    swap_en = 1'b1;
    send_words(0, N, N - 1, 32'h0000_1000);
    wait_done();
    swap_en = 1'b0;
    check("reload_bank", W'(active_bank), 32'd0);
    read_check("reload_addr37", 8'd37, 32'h0000_1025);
    read_check("reload_addr7",  8'd7,  32'h0000_1007);
    idle(2);
    check("reload_done_count", W'(done_cnt - d0), 32'd1);
    check("reload_err_count",  W'(err_cnt - e0),  32'd1);

    // Long set: 165 words, error at word 159, remainder drained, no swap.
    e0 = err_cnt;
    d0 = done_cnt;
    swap_en = 1'b1;
    send_words(0, N, -1, 32'hbeef_0000);
    check("long_err_at_159", W'(load_error), 32'd1);
    send_words(N, 5, N + 4, 32'hbeef_0000);
    idle(3);
    swap_en = 1'b0;
    check("long_err_count",  W'(err_cnt - e0),  32'd1);
    check("long_done_count", W'(done_cnt - d0), 32'd0);
    check("long_bank",       W'(active_bank),   32'd0);
    read_check("long_keep37", 8'd37, 32'h0000_1025);

    // Reset in the middle of a load.
    send_words(0, 81, -1, 32'h5555_0000);
    rst            = 1'b1;
    s_bus.s_tvalid = 1'b1;
    s_bus.s_tdata  = 32'h5555_0051;
    #1;
    check("midrst_tready", W'(s_bus.s_tready), 32'd0);
    @(negedge clk);
    rst            = 1'b0;
    s_bus.s_tvalid = 1'b0;
    check("midrst_bank", W'(active_bank), 32'd0);
    read_check("midrst_keep37", 8'd37, 32'h0000_1025);
    read_check("midrst_keep80", 8'd80, 32'h0000_1050);
    swap_en = 1'b1;
    send_words(0, N, N - 1, 32'h0000_7000);
    wait_done();
    swap_en = 1'b0;
    check("fresh_bank", W'(active_bank), 32'd1);
    read_check("fresh_addr0",   8'd0,   32'h0000_7000);
    read_check("fresh_addr80",  8'd80,  32'h0000_7050);
    read_check("fresh_addr159", 8'd159, 32'h0000_709f);

`ifdef EQ_COEFF_BANK_READBACK_EN
    rb_bank       = 1'b1;
    rb_addr       = 8'd100;
    eq_coeff_addr = 8'd37;
    @(negedge clk);
    check("rb_active_100",  rb_data,  32'h0000_7064);
    check("rb_concurrent",  eq_coeff, 32'h0000_7025);
    rb_bank = 1'b0;
    @(negedge clk);
    check("rb_shadow_100",  rb_data,  32'h0000_1064);
    rb_addr = 8'd200;
    @(negedge clk);
    check("rb_out_of_range", rb_data, 32'd0);
`endif

    check("done_error_exclusive", W'(both_seen), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
